// File: rtl/pwm_multi_if.sv
// Configuration bus from the control register block into the PWM generator.
// Latency: none (wires only); the write strobe is a single-cycle pulse.
// Backpressure: none; every cfg_wr is captured on the clock edge that samples it.
interface pwm_multi_if #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4
);
   logic                    cfg_wr;
   logic [WIDTH-1:0]        cfg_period;
   logic [NUM_CH*WIDTH-1:0] cfg_duty;
   logic                    cfg_center;
   logic [NUM_CH-1:0]       cfg_polarity;

   modport master (
      output cfg_wr, cfg_period, cfg_duty, cfg_center, cfg_polarity
   );

   modport slave (
      input  cfg_wr, cfg_period, cfg_duty, cfg_center, cfg_polarity
   );
endinterface

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared frame counter, per-channel duty/polarity, edge or center mode.
// Latency: one clock from counter value to pwm_out/frame_start; config commits at frame boundaries.
// Backpressure: none; a later cfg_wr before the boundary overwrites the shadow copy.
module pwm_multi #(
   parameter int WIDTH  = 16,
   parameter int NUM_CH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              enable,
   pwm_multi_if.slave        cfg,
   output logic [NUM_CH-1:0] pwm_out,
   output logic              frame_start,
   output logic              update_pending
);

   typedef struct packed {
      logic [WIDTH-1:0]        period;
      logic [NUM_CH*WIDTH-1:0] duty;
      logic                    center;
      logic [NUM_CH-1:0]       pol;
   } cfg_t;

   typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_e;

   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0]  cnt_q, cnt_d;
   dir_e              dir_q, dir_d;
   cfg_t              shadow_q, shadow_d;
   cfg_t              active_q, active_d;
   cfg_t              cfg_in;
   logic              pend_q, pend_d;
   logic [NUM_CH-1:0] pwm_q, pwm_d;
   logic              fs_q, fs_d;
   logic              wrap;

   // Collect the interface fields into one config word.
   always_comb begin
      cfg_in        = '0;
      cfg_in.period = cfg.cfg_period;
      cfg_in.duty   = cfg.cfg_duty;
      cfg_in.center = cfg.cfg_center;
      cfg_in.pol    = cfg.cfg_polarity;
   end

   // Counter sequencing; wrap marks the edge at which cnt becomes 0 for a new frame.
   // While disabled every cycle counts as a boundary so active tracks the shadow.
   always_comb begin
      cnt_d = cnt_q;
      dir_d = dir_q;
      wrap  = 1'b0;
      if (!enable || active_q.period == ZERO) begin
         cnt_d = ZERO;
         dir_d = DIR_UP;
         wrap  = 1'b1;
      end else if (!active_q.center) begin
         if (cnt_q >= active_q.period) begin
            cnt_d = ZERO;
            wrap  = 1'b1;
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end else if (dir_q == DIR_UP) begin
         if (cnt_q >= active_q.period) begin
            // With P=1 the down ramp is empty: 0,1 then straight back to 0.
            if (active_q.period == ONE) begin
               cnt_d = ZERO;
               wrap  = 1'b1;
            end else begin
               cnt_d = active_q.period - ONE;
               dir_d = DIR_DOWN;
            end
         end else begin
            cnt_d = cnt_q + ONE;
         end
      end else begin
         if (cnt_q <= ONE) begin
            cnt_d = ZERO;
            dir_d = DIR_UP;
            wrap  = 1'b1;
         end else begin
            cnt_d = cnt_q - ONE;
         end
      end
   end

   // Shadow capture and commit; a write on the boundary edge bypasses the shadow.
   always_comb begin
      shadow_d = cfg.cfg_wr ? cfg_in : shadow_q;
      active_d = active_q;
      pend_d   = pend_q | cfg.cfg_wr;
      if (wrap) begin
         active_d = cfg.cfg_wr ? cfg_in : shadow_q;
         pend_d   = 1'b0;
      end
   end

   // Compare stage: outputs sit at the idle (polarity) level while disabled.
   always_comb begin
      pwm_d = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (enable)
            pwm_d[i] = (cnt_q < active_q.duty[i*WIDTH +: WIDTH]) ^ active_q.pol[i];
         else
            pwm_d[i] = active_q.pol[i];
      end
      fs_d = enable && (cnt_q == ZERO);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= ZERO;
         dir_q    <= DIR_UP;
         shadow_q <= '0;
         active_q <= '0;
         pend_q   <= 1'b0;
         pwm_q    <= '0;
         fs_q     <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         dir_q    <= dir_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         pwm_q    <= pwm_d;
         fs_q     <= fs_d;
      end
   end

   assign pwm_out        = pwm_q;
   assign frame_start    = fs_q;
   assign update_pending = pend_q;

endmodule
